// File: rtl/tile_pixel_walker.sv
// tile_pixel_walker: buffers tile origins from the tile generator in a small
// FIFO and walks each tile row-major, emitting one pixel coordinate per cycle
// on a valid/ready stream. Optional clipping to the screen rectangle is
// enabled by defining TILE_WALKER_CLIP_EN.
module tile_pixel_walker #(
  parameter int T          = 16,
  parameter int COORD_W    = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tile_valid,
  input  logic [COORD_W-1:0] tile_x,
  input  logic [COORD_W-1:0] tile_y,
  input  logic               tile_done,
  output logic               tile_ready,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_last,
  output logic               frame_done,
  output logic               overflow
);

  // Limits and offsets carry one extra bit so SCREEN - origin never wraps.
  localparam int LW = COORD_W + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [LW-1:0] T_L     = LW'(T);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WALK, FINISH} state_t;

  state_t               state_q;
  logic [2*COORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 done_pending_q, overflow_q;
  logic [COORD_W-1:0]   cur_x_q, cur_y_q;
  logic [LW-1:0]        ox_q, oy_q, w_lim_q, h_lim_q;
  logic                 pix_valid_q, pix_last_q, frame_done_q;
  logic [COORD_W-1:0]   pix_x_q, pix_y_q;

  logic                 full, empty, push, pop, hs;
  logic [COORD_W-1:0]   head_x, head_y;
  logic [LW-1:0]        head_w, head_h;
  logic                 x_wrap;
  logic [LW-1:0]        ox_nxt, oy_nxt;
  logic                 last_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

`ifdef TILE_WALKER_CLIP_EN
  // Visible extent of a tile starting at org on an axis of length scr.
  function automatic logic [LW-1:0] clip_lim(input logic [COORD_W-1:0] org,
                                             input logic [LW-1:0]      scr);
    logic [LW-1:0] rem;
    if ({1'b0, org} >= scr) return '0;
    rem = scr - {1'b0, org};
    return (rem < T_L) ? rem : T_L;
  endfunction
`endif

  // Fullness is judged before any same-cycle pop, so a push into a full
  // FIFO is dropped even while the walker is popping.
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);
  assign push       = tile_valid && !full;
  assign pop        = (state_q == IDLE) && !empty;
  assign hs         = pix_valid_q && pix_ready;
  assign head_x     = mem_q[rd_ptr_q][2*COORD_W-1:COORD_W];
  assign head_y     = mem_q[rd_ptr_q][COORD_W-1:0];
  assign tile_ready = !full;

  // Per-tile limits of the FIFO head and the next raster offset in the walk.
  always_comb begin
`ifdef TILE_WALKER_CLIP_EN
    head_w = clip_lim(head_x, LW'(SCREEN_W));
    head_h = clip_lim(head_y, LW'(SCREEN_H));
`else
    head_w = T_L;
    head_h = T_L;
`endif
    x_wrap   = (ox_q == w_lim_q - LW'(1));
    ox_nxt   = x_wrap ? '0 : ox_q + LW'(1);
    oy_nxt   = x_wrap ? oy_q + LW'(1) : oy_q;
    last_nxt = (ox_nxt == w_lim_q - LW'(1)) && (oy_nxt == h_lim_q - LW'(1));
  end

  // Tile storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tile_x, tile_y};
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
      if (tile_valid && full) overflow_q <= 1'b1;
    end
  end

  // Walker FSM with registered pixel outputs and end-of-frame handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pix_valid_q    <= 1'b0;
      pix_last_q     <= 1'b0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      frame_done_q   <= 1'b0;
      done_pending_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (tile_done) done_pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            cur_x_q <= head_x;
            cur_y_q <= head_y;
            ox_q    <= '0;
            oy_q    <= '0;
            w_lim_q <= head_w;
            h_lim_q <= head_h;
            // Fully clipped tiles are consumed without emitting anything.
            if ((head_w != '0) && (head_h != '0)) begin
              state_q     <= WALK;
              pix_valid_q <= 1'b1;
              pix_x_q     <= head_x;
              pix_y_q     <= head_y;
              pix_last_q  <= (head_w == LW'(1)) && (head_h == LW'(1));
            end
          end else if (done_pending_q) begin
            state_q      <= FINISH;
            frame_done_q <= 1'b1;
          end
        end
        WALK: begin
          if (hs) begin
            if (pix_last_q) begin
              state_q     <= IDLE;
              pix_valid_q <= 1'b0;
              pix_last_q  <= 1'b0;
            end else begin
              ox_q       <= ox_nxt;
              oy_q       <= oy_nxt;
              pix_x_q    <= cur_x_q + ox_nxt[COORD_W-1:0];
              pix_y_q    <= cur_y_q + oy_nxt[COORD_W-1:0];
              pix_last_q <= last_nxt;
            end
          end
        end
        FINISH: begin
          // A fresh done pulse arriving right now is kept for the next frame.
          done_pending_q <= tile_done;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pix_valid  = pix_valid_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_last   = pix_last_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tile_pixel_walker.sv
// Testbench for tile_pixel_walker: expected pixel stream built per tile from
// the raster rules, compared against every valid pixel the DUT presents.
module tb_tile_pixel_walker;

  localparam int T   = 16;
  localparam int CW  = 10;
  localparam int SW  = 640;
  localparam int SH  = 480;

  logic          clk = 1'b0;
  logic          rst;
  logic          tile_valid;
  logic [CW-1:0] tile_x, tile_y;
  logic          tile_done;
  logic          tile_ready;
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_last;
  logic          frame_done;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned exp_q[$];
  int          hs_cnt = 0;
  int          fd_cnt = 0;
  bit          mon_en = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          rdy_val  = 1'b1;

  tile_pixel_walker #(.T(T), .COORD_W(CW), .FIFO_DEPTH(4),
                      .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .rst(rst),
    .tile_valid(tile_valid), .tile_x(tile_x), .tile_y(tile_y),
    .tile_done(tile_done), .tile_ready(tile_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: visible extent of a tile along one axis.
  function automatic int extent(input int org, input int scr);
`ifdef TILE_WALKER_CLIP_EN
    if (org >= scr) return 0;
    return (scr - org < T) ? scr - org : T;
`else
    return (scr >= 0) ? T + 0 * org : T;
`endif
  endfunction

  function automatic int unsigned pack(input int x, input int y, input bit last);
    return {11'b0, last, 10'(y % 1024), 10'(x % 1024)};
  endfunction

  task automatic add_tile(input int x, input int y);
    int w = extent(x, SW);
    int h = extent(y, SH);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back(pack(x + c, y + r, (r == h - 1) && (c == w - 1)));
  endtask

  task automatic drive(input bit v, input int x, input int y, input bit d);
    @(posedge clk); #1;
    tile_valid = v;
    tile_x     = 10'(x);
    tile_y     = 10'(y);
    tile_done  = d;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // Downstream ready: constant or random per cycle.
  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      pix_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    end
  end

  // Monitor: every presented pixel must equal the head of the expected stream.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (pix_valid) begin
          if (exp_q.size() == 0) chk("extra_pix", {31'b0, pix_valid}, 32'd0);
          else begin
            chk("pix", {11'b0, pix_last, pix_y, pix_x}, exp_q[0]);
            if (pix_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
        if (frame_done) begin
          fd_cnt++;
          chk("fd_early", exp_q.size(), 0);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; tile_valid = 1'b0; tile_x = '0; tile_y = '0; tile_done = 1'b0;
    cycles(3);
    chk("rst_pix_valid", {31'b0, pix_valid}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_tile_ready", {31'b0, tile_ready}, 1);
    rst = 1'b0;
    mon_en = 1'b1;
    cycles(2);

    // Single tile with latency check, then end-of-stream.
    rdy_val = 1'b1; fd_cnt = 0;
    add_tile(0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("lat_n1", {31'b0, pix_valid}, 0);
    @(negedge clk);
    chk("lat_n2", {31'b0, pix_valid}, 1);
    cycles(20);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    wait_drain(1000);
    cycles(8);
    chk("frame_done_cnt1", fd_cnt, 1);

    // Overflow: walker stalled on one tile, then five back-to-back pulses.
    rdy_val = 1'b0;
    add_tile(16, 0);
    drive(1, 16, 0, 0);
    drive(0, 0, 0, 0);
    cycles(3);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) add_tile(32 * i, 48);
      drive(1, 32 * i, 48, 0);
    end
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("ovf_flag", {31'b0, overflow}, 1);
    chk("ovf_tile_ready", {31'b0, tile_ready}, 0);
    rdy_val = 1'b1;
    wait_drain(3000);
    chk("ovf_sticky", {31'b0, overflow}, 1);

    // Random stalls on tile (32,16).
    rdy_rand = 1'b1;
    add_tile(32, 16);
    drive(1, 32, 16, 0);
    drive(0, 0, 0, 0);
    wait_drain(3000);
    rdy_rand = 1'b0;

    // Reset in the middle of a walk.
    rdy_val = 1'b1; hs_cnt = 0;
    add_tile(0, 0);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    begin
      int k = 0;
      while (hs_cnt < 100 && k < 1000) begin
        @(posedge clk); #1; k++;
      end
      chk("reach_pix100", (hs_cnt >= 100) ? 1 : 0, 1);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, pix_valid}, 0);
    chk("mid_rst_ovf", {31'b0, overflow}, 0);
    chk("mid_rst_ready", {31'b0, tile_ready}, 1);
    exp_q.delete();
    mon_en = 1'b1;
    cycles(4);
    add_tile(64, 64);
    drive(1, 64, 64, 0);
    drive(0, 0, 0, 0);
    wait_drain(1000);

    // Tile and done in the same cycle.
    fd_cnt = 0;
    add_tile(128, 32);
    drive(1, 128, 32, 1);
    drive(0, 0, 0, 0);
    wait_drain(1000);
    cycles(8);
    chk("frame_done_cnt2", fd_cnt, 1);

`ifdef TILE_WALKER_CLIP_EN
    // Partially and fully off-screen tiles.
    add_tile(632, 472);
    drive(1, 632, 472, 0);
    drive(0, 0, 0, 0);
    wait_drain(500);
    drive(1, 640, 0, 0);
    drive(0, 0, 0, 0);
    cycles(6);
    chk("clip_offscreen", {31'b0, pix_valid}, 0);
`endif

    // Random tiles, including coordinate wrap, under random stalls.
    rdy_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int x = (i == 0) ? 1016 : int'($urandom_range(0, 1023));
      int y = (i == 0) ? 1020 : int'($urandom_range(0, 1023));
      add_tile(x, y);
      drive(1, x, y, 0);
      drive(0, 0, 0, 0);
      wait_drain(2000);
    end
    rdy_rand = 1'b0;
    cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
